uart_calc_core: RTL

//  Parametrised UART command engine for the S7 calculator. Collects a WIDTH-bit operand pair and a command byte from a

---
 rtl/uart_calc_core.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_calc_core.sv
// UART command engine: receives OP1/OP2 (WIDTH bits each, LSB byte first) and a command byte,
// runs the ALU and returns result bytes plus a status byte. Optional inter-byte timeout: UART_CALC_TIMEOUT_EN.
module uart_calc_core #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [2:0]       state,
    output logic             rx_drop,
    output logic             frame_err
);
    localparam int NB  = WIDTH / 8;
    localparam int SHW = $clog2(WIDTH);
    localparam logic [1:0] CNT_LAST = 2'(NB - 1);

    localparam logic [2:0] ST_RX_OP1  = 3'd0;
    localparam logic [2:0] ST_RX_OP2  = 3'd1;
    localparam logic [2:0] ST_RX_CMD  = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_TX_BYTE = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_calc_core: illegal WIDTH or TIMEOUT_CYCLES");
    end

    function automatic logic [7:0] status_byte(input logic [WIDTH-1:0] res, input logic c);
        return {5'b00000, res[WIDTH-1], (res == {WIDTH{1'b0}}), c};
    endfunction

    logic [2:0]         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, result_q, result_d;
    logic [7:0]         cmd_q, cmd_d, tx_data_q, tx_data_d;
    logic [WIDTH+7:0]   tx_buf_q, tx_buf_d;
    logic [2:0]         tx_left_q, tx_left_d;
    logic               tx_first_q, tx_first_d;
    logic               tx_start_q, tx_start_d, result_valid_q, result_valid_d;
    logic               rx_drop_q, rx_drop_d, frame_err_q, frame_err_d;

    logic [WIDTH:0]     sum_s, diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   alu_res_s, byte_mask_s, byte_val_s;
    logic               alu_c_s;
    logic [4:0]         byte_sh_s;

    assign sum_s       = {1'b0, op1_q} + {1'b0, op2_q};
    assign diff_s      = {1'b0, op1_q} - {1'b0, op2_q};
    assign prod_s      = {{WIDTH{1'b0}}, op1_q} * {{WIDTH{1'b0}}, op2_q};
    assign byte_sh_s   = {cnt_q, 3'b000};
    assign byte_mask_s = WIDTH'(8'hFF) << byte_sh_s;
    assign byte_val_s  = WIDTH'(rx_data) << byte_sh_s;

    // ALU: result and carry/borrow/overflow flag for the latched command
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        case (cmd_q[2:0])
            3'd0: begin alu_res_s = sum_s[WIDTH-1:0];  alu_c_s = sum_s[WIDTH];  end
            3'd1: begin alu_res_s = diff_s[WIDTH-1:0]; alu_c_s = diff_s[WIDTH]; end
            3'd2: alu_res_s = op1_q & op2_q;
            3'd3: alu_res_s = op1_q | op2_q;
            3'd4: alu_res_s = op1_q ^ op2_q;
            3'd5: alu_res_s = op1_q << op2_q[SHW-1:0];
            3'd6: alu_res_s = op1_q >> op2_q[SHW-1:0];
            3'd7: begin
                alu_res_s = prod_s[WIDTH-1:0];
                alu_c_s   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            end
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef UART_CALC_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_armed_s;
    assign tmo_armed_s = (state_q == ST_RX_OP2) || (state_q == ST_RX_CMD) ||
                         ((state_q == ST_RX_OP1) && (cnt_q != 2'd0));
`endif

    // Frame FSM next-state, byte capture, transmit queue and output pulses
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        cmd_d          = cmd_q;
        result_d       = result_q;
        tx_data_d      = tx_data_q;
        tx_buf_d       = tx_buf_q;
        tx_left_d      = tx_left_q;
        tx_first_d     = tx_first_q;
        tx_start_d     = 1'b0;
        result_valid_d = 1'b0;
        rx_drop_d      = 1'b0;
        frame_err_d    = 1'b0;
        case (state_q)
            ST_RX_OP1, ST_RX_OP2: begin
                if (rx_ready) begin
                    if (state_q == ST_RX_OP1) begin
                        op1_d = (op1_q & ~byte_mask_s) | byte_val_s;
                    end else begin
                        op2_d = (op2_q & ~byte_mask_s) | byte_val_s;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = 2'd0;
                        state_d = (state_q == ST_RX_OP1) ? ST_RX_OP2 : ST_RX_CMD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RX_CMD: begin
                if (rx_ready) begin
                    cmd_d   = rx_data;
                    state_d = ST_EXEC;
                end else begin
                    cmd_d = cmd_q;
                end
            end
            ST_EXEC: begin
                rx_drop_d = rx_ready;
                state_d   = ST_TX_BYTE;
                if (cmd_q[7:3] != 5'd0) begin
                    frame_err_d = 1'b1;
                    tx_buf_d    = {{WIDTH{1'b0}}, 8'hEE};
                    tx_left_d   = 3'd1;
                end else begin
                    result_d       = alu_res_s;
                    result_valid_d = 1'b1;
                    tx_buf_d       = {status_byte(alu_res_s, alu_c_s), alu_res_s};
                    tx_left_d      = 3'(NB + 1);
                end
            end
            ST_TX_BYTE: begin
                rx_drop_d = rx_ready;
                if (!tx_busy) begin
                    tx_data_d  = tx_buf_q[7:0];
                    tx_start_d = 1'b1;
                    tx_buf_d   = tx_buf_q >> 8;
                    tx_left_d  = tx_left_q - 3'd1;
                    tx_first_d = 1'b1;
                    state_d    = ST_TX_WAIT;
                end else begin
                    state_d = ST_TX_BYTE;
                end
            end
            ST_TX_WAIT: begin
                rx_drop_d = rx_ready;
                // busy may lag tx_start by a cycle, so the first cycle never decides
                if (tx_first_q) begin
                    tx_first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = (tx_left_q != 3'd0) ? ST_TX_BYTE : ST_RX_OP1;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            default: begin
                state_d = ST_RX_OP1;
                cnt_d   = 2'd0;
            end
        endcase
`ifdef UART_CALC_TIMEOUT_EN
        tmo_d = tmo_q;
        if (!tmo_armed_s || rx_ready) begin
            tmo_d = 32'd0;
        end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
            tmo_d       = 32'd0;
            state_d     = ST_RX_OP1;
            cnt_d       = 2'd0;
            op1_d       = {WIDTH{1'b0}};
            op2_d       = {WIDTH{1'b0}};
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q        <= ST_RX_OP1;
            cnt_q          <= 2'd0;
            op1_q          <= {WIDTH{1'b0}};
            op2_q          <= {WIDTH{1'b0}};
            cmd_q          <= 8'h00;
            result_q       <= {WIDTH{1'b0}};
            tx_data_q      <= 8'h00;
            tx_buf_q       <= {(WIDTH+8){1'b0}};
            tx_left_q      <= 3'd0;
            tx_first_q     <= 1'b0;
            tx_start_q     <= 1'b0;
            result_valid_q <= 1'b0;
            rx_drop_q      <= 1'b0;
            frame_err_q    <= 1'b0;
`ifdef UART_CALC_TIMEOUT_EN
            tmo_q          <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            cmd_q          <= cmd_d;
            result_q       <= result_d;
            tx_data_q      <= tx_data_d;
            tx_buf_q       <= tx_buf_d;
            tx_left_q      <= tx_left_d;
            tx_first_q     <= tx_first_d;
            tx_start_q     <= tx_start_d;
            result_valid_q <= result_valid_d;
            rx_drop_q      <= rx_drop_d;
            frame_err_q    <= frame_err_d;
`ifdef UART_CALC_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign state        = state_q;
    assign rx_drop      = rx_drop_q;
    assign frame_err    = frame_err_q;
endmodule
